// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding a 2-entry output FIFO with a per-word byte address.
// Optional macro RVENC_RANGE_CHECK_EN flags immediates that do not fit their encoding.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic        in_funct7b5,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Returns {err, instr}; illegal classes become a nop flagged as an error.
  function automatic logic [32:0] encode(
    input logic [2:0]  fmt,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [31:0] imm
  );
    logic [31:0] w;
    logic        err;
    w   = 32'h0000_0013;
    err = 1'b0;
    case (fmt)
      3'd0: w = {imm[11:0], rs1, f3, rd, OP_LOAD};
      3'd1: w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      3'd2: w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, OP_REG};
      3'd3: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      3'd4: begin
        if (f3 == 3'b001) begin
          w = {7'b0000000, imm[4:0], rs1, f3, rd, OP_IMM};
        end else if (f3 == 3'b101) begin
          w = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, OP_IMM};
        end else begin
          w = {imm[11:0], rs1, f3, rd, OP_IMM};
        end
      end
      3'd5: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      default: begin
        w   = 32'h0000_0013;
        err = 1'b1;
      end
    endcase
`ifdef RVENC_RANGE_CHECK_EN
    case (fmt)
      3'd0, 3'd1, 3'd4:
        err = ($signed(imm) < -32'sd2048) || ($signed(imm) > 32'sd2047);
      3'd3:
        err = ($signed(imm) < -32'sd4096) || ($signed(imm) > 32'sd4094) || imm[0];
      3'd5:
        err = ($signed(imm) < -32'sd1048576) || ($signed(imm) > 32'sd1048574) || imm[0];
      default: err = err;
    endcase
`endif
    return {err, w};
  endfunction

`ifndef RVENC_RANGE_CHECK_EN
  logic unused_imm_bits;
  assign unused_imm_bits = ^in_imm[31:21];
`endif

  logic [32:0] mem_q [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic        push, pop;
  logic [32:0] enc;
  logic [32:0] head;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign enc       = encode(in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm);
  assign head      = mem_q[rd_ptr_q];
  assign out_instr = out_valid ? head[31:0] : 32'h0000_0000;
  assign out_err   = out_valid & head[32];
  assign out_addr  = addr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      addr_d   = addr_q + 32'd4;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= 33'd0;
      mem_q[1] <= 33'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      addr_q   <= BASE_ADDR;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= enc;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver pushes expected words, monitor checks on output handshakes.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;

  instr_encoder #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_addr = BASE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: compare each output handshake against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_addr = BASE;
      end else if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got 0x%08h expected no output", out_instr);
        end else begin
          e = sb.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_addr", out_addr, exp_addr);
          chk("out_err", {31'd0, out_err}, {31'd0, e.err});
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                      input logic [31:0] imm, input logic [31:0] e_instr, input logic e_err);
    exp_t e;
    bit   done;
    done        = 1'b0;
    in_fmt      = fmt;
    in_rd       = rd;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_funct3   = f3;
    in_funct7b5 = f7b5;
    in_imm      = imm;
    in_valid    = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.instr = e_instr;
        e.err   = e_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready 0 expected acceptance");
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    bit range_chk;
`ifdef RVENC_RANGE_CHECK_EN
    range_chk = 1'b1;
`else
    range_chk = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = 3'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
    in_funct3 = 3'd0; in_funct7b5 = 1'b0; in_imm = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_out_addr", out_addr, BASE);

    // Backpressure: two fill the FIFO, third waits until the consumer drains.
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 32'd8, 32'h0081_2283, 1'b0);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    send(3'd1, 5'd0, 5'd2, 5'd6, 3'b010, 1'b0, 32'd12, 32'h0061_2623, 1'b0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    send(3'd2, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 32'd0, 32'h4031_00B3, 1'b0);
    drain();

    // Streaming with out_ready high, covering every class and the shift forms.
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, -32'sd4, 32'hFE20_8EE3, 1'b0);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8, 32'h0080_00EF, 1'b0);
    send(3'd4, 5'd3, 5'd4, 5'd0, 3'b101, 1'b1, 32'd5, 32'h4052_5193, 1'b0);
    send(3'd4, 5'd3, 5'd4, 5'd0, 3'b001, 1'b1, 32'h25, 32'h0052_1193, 1'b0);
    send(3'd7, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 32'd8, 32'h0000_0013, 1'b1);
    send(3'd6, 5'd9, 5'd9, 5'd9, 3'b111, 1'b1, 32'd0, 32'h0000_0013, 1'b1);
    send(3'd4, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd4096, 32'h0000_0093, range_chk);
    drain();

    // Reset with two entries buffered: nothing emitted, address restarts.
    out_ready = 1'b0;
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'b010, 1'b0, 32'd8, 32'h0081_2283, 1'b0);
    send(3'd1, 5'd0, 5'd2, 5'd6, 3'b010, 1'b0, 32'd12, 32'h0061_2623, 1'b0);
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_addr", out_addr, BASE);
    out_ready = 1'b1;
    send(3'd2, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 32'd0, 32'h4031_00B3, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
